// File: rtl/mode_sequencer_pkg.sv
// Shared definitions for the mode sequencer: mode indices, FSM encoding and
// blanking defaults.
package mode_sequencer_pkg;

  localparam int NUM_MODES = 4;

  localparam logic [1:0] MODE_0 = 2'd0;
  localparam logic [1:0] MODE_1 = 2'd1;
  localparam logic [1:0] MODE_2 = 2'd2;
  localparam logic [1:0] MODE_3 = 2'd3;  // credits

  localparam logic [15:0] BLANK_SEG_DEFAULT = 16'hFFFF;

  typedef enum logic {
    BLANK = 1'b0,
    RUN   = 1'b1
  } state_t;

  function automatic logic [NUM_MODES-1:0] mode_onehot(input logic [1:0] mode);
    mode_onehot = '0;
    mode_onehot[mode] = 1'b1;
  endfunction

endpackage

// File: rtl/btn_sync_edge.sv
// Two-flop synchronizer plus rising-edge detector for one debounced button.
// A level already high across reset never produces a request.
module btn_sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic req
);

  logic stage1;
  logic stage2;
  logic stage2_d;
  logic [1:0] settle;

  // Until the synchronizer holds a post-reset sample, the edge-detect flop
  // tracks the incoming level so the first real sample is taken as baseline.
  always_ff @(posedge clk) begin
    if (reset) begin
      stage1   <= 1'b0;
      stage2   <= 1'b0;
      stage2_d <= 1'b0;
      settle   <= 2'b00;
    end else begin
      stage1   <= btn;
      stage2   <= stage1;
      settle   <= {settle[0], 1'b1};
      stage2_d <= settle[1] ? stage2 : stage1;
    end
  end

  assign req = stage2 & ~stage2_d;

endmodule

// File: rtl/mode_sequencer.sv
// Selects one of four mode blocks with next/prev buttons, inserting a blanking
// interval between modes so no two blocks are ever enabled together.
module mode_sequencer
  import mode_sequencer_pkg::*;
#(
  parameter int          BLANK_CYCLES = 10_000_000,
  parameter logic [15:0] BLANK_SEG    = BLANK_SEG_DEFAULT
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 btn_next,
  input  logic                 btn_prev,
  input  logic [15:0]          led0,
  input  logic [15:0]          led1,
  input  logic [15:0]          led2,
  input  logic [15:0]          led3,
  input  logic [15:0]          seg0,
  input  logic [15:0]          seg1,
  input  logic [15:0]          seg2,
  input  logic [15:0]          seg3,
  output logic [NUM_MODES-1:0] mode_active,
  output logic [1:0]           cur_mode,
  output logic [15:0]          led,
  output logic [15:0]          seg_data
);

  localparam int CNT_W = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLANK_CYCLES - 1);

  logic next_req;
  logic prev_req;
  state_t state;
  logic [CNT_W-1:0] blank_cnt;
  logic [15:0] led_sel;
  logic [15:0] seg_sel;

  btn_sync_edge u_next (
    .clk   (clk),
    .reset (reset),
    .btn   (btn_next),
    .req   (next_req)
  );

  btn_sync_edge u_prev (
    .clk   (clk),
    .reset (reset),
    .btn   (btn_prev),
    .req   (prev_req)
  );

  always_comb begin
    led_sel = led0;
    seg_sel = seg0;
    case (cur_mode)
      MODE_0: begin led_sel = led0; seg_sel = seg0; end
      MODE_1: begin led_sel = led1; seg_sel = seg1; end
      MODE_2: begin led_sel = led2; seg_sel = seg2; end
      MODE_3: begin led_sel = led3; seg_sel = seg3; end
      default: begin led_sel = led0; seg_sel = seg0; end
    endcase
  end

  // Requests only matter in RUN; a request seen while blanking is dropped.
  // Opposing requests in one cycle cancel out.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= BLANK;
      blank_cnt   <= '0;
      cur_mode    <= MODE_0;
      mode_active <= '0;
      led         <= 16'h0000;
      seg_data    <= BLANK_SEG;
    end else begin
      case (state)
        BLANK: begin
          if (blank_cnt == CNT_LAST) begin
            state       <= RUN;
            mode_active <= mode_onehot(cur_mode);
          end else begin
            blank_cnt <= blank_cnt + CNT_W'(1);
          end
        end
        RUN: begin
          if (next_req != prev_req) begin
            cur_mode    <= next_req ? cur_mode + 2'd1 : cur_mode - 2'd1;
            state       <= BLANK;
            blank_cnt   <= '0;
            mode_active <= '0;
            led         <= 16'h0000;
            seg_data    <= BLANK_SEG;
          end else begin
            led      <= led_sel;
            seg_data <= seg_sel;
          end
        end
        default: begin
          state <= BLANK;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mode_sequencer.sv
// Randomized and directed bench for mode_sequencer against a behavioural
// model of the mode/blanking rules.
module tb_mode_sequencer;

  localparam int BC = 4;

  logic clk = 1'b0;
  logic reset;
  logic btn_next;
  logic btn_prev;
  logic [15:0] led_in [4];
  logic [15:0] seg_in [4];
  logic [3:0]  mode_active;
  logic [1:0]  cur_mode;
  logic [15:0] led;
  logic [15:0] seg_data;

  int checks = 0;
  int errors = 0;

  int          m_mode;
  bit          m_running;
  int          m_blank_left;
  logic [3:0]  m_active;
  logic [15:0] m_led;
  logic [15:0] m_seg;
  bit          hist_next[$];
  bit          hist_prev[$];

  always #5 clk = ~clk;

  mode_sequencer #(
    .BLANK_CYCLES (BC),
    .BLANK_SEG    (16'hFFFF)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .btn_next    (btn_next),
    .btn_prev    (btn_prev),
    .led0        (led_in[0]),
    .led1        (led_in[1]),
    .led2        (led_in[2]),
    .led3        (led_in[3]),
    .seg0        (seg_in[0]),
    .seg1        (seg_in[1]),
    .seg2        (seg_in[2]),
    .seg3        (seg_in[3]),
    .mode_active (mode_active),
    .cur_mode    (cur_mode),
    .led         (led),
    .seg_data    (seg_data)
  );

  // A request is a rise between two post-reset button samples, seen two
  // edges after the sample that rose.
  task automatic modelEdge();
    bit rn;
    bit rp;
    int e;
    if (reset) begin
      m_mode       = 0;
      m_running    = 0;
      m_blank_left = BC;
      m_active     = 4'b0000;
      m_led        = 16'h0000;
      m_seg        = 16'hFFFF;
      hist_next.delete();
      hist_prev.delete();
      return;
    end
    hist_next.push_back(btn_next);
    hist_prev.push_back(btn_prev);
    e  = hist_next.size();
    rn = (e >= 4) && hist_next[e-3] && !hist_next[e-4];
    rp = (e >= 4) && hist_prev[e-3] && !hist_prev[e-4];
    if (!m_running) begin
      m_blank_left--;
      if (m_blank_left == 0) begin
        m_running = 1;
        m_active  = 4'(1 << m_mode);
      end
    end else if (rn != rp) begin
      m_mode       = rn ? (m_mode + 1) % 4 : (m_mode + 3) % 4;
      m_running    = 0;
      m_blank_left = BC;
      m_active     = 4'b0000;
      m_led        = 16'h0000;
      m_seg        = 16'hFFFF;
    end else begin
      m_led = led_in[m_mode];
      m_seg = seg_in[m_mode];
    end
  endtask

  task automatic checkValue(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput();
    checkValue("mode_active", {12'h000, mode_active}, {12'h000, m_active});
    checkValue("cur_mode", {14'h0000, cur_mode}, 16'(m_mode));
    checkValue("led", led, m_led);
    checkValue("seg_data", seg_data, m_seg);
    checkValue("onehot", 16'($countones(mode_active) <= 1), 16'd1);
  endtask

  task automatic applyStimulus(input bit rst, input bit nxt, input bit prv, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      reset    = rst;
      btn_next = nxt;
      btn_prev = prv;
      for (int k = 0; k < 4; k++) begin
        led_in[k] = 16'($urandom);
        seg_in[k] = 16'($urandom);
      end
      modelEdge();
      @(posedge clk);
      #1;
      checkOutput();
    end
  endtask

  initial begin
    bit rn;
    bit rp;
    reset    = 1'b1;
    btn_next = 1'b0;
    btn_prev = 1'b0;
    for (int k = 0; k < 4; k++) begin
      led_in[k] = 16'h0;
      seg_in[k] = 16'h0;
    end

    applyStimulus(1, 0, 0, 3);
    checkValue("reset_active", {12'h000, mode_active}, 16'h0000);
    checkValue("reset_seg", seg_data, 16'hFFFF);
    checkValue("reset_led", led, 16'h0000);

    applyStimulus(0, 0, 0, 3);
    checkValue("blank_hold", {12'h000, mode_active}, 16'h0000);
    applyStimulus(0, 0, 0, 1);
    checkValue("first_run", {12'h000, mode_active}, 16'h0001);
    applyStimulus(0, 0, 0, 4);

    for (int p = 0; p < 3; p++) begin
      applyStimulus(0, 1, 0, 1);
      applyStimulus(0, 0, 0, 9);
    end
    checkValue("at_mode3", {14'h0000, cur_mode}, 16'd3);

    applyStimulus(0, 1, 0, 1);
    applyStimulus(0, 0, 0, 2);
    checkValue("wrap_mode", {14'h0000, cur_mode}, 16'd0);
    checkValue("wrap_blank", {12'h000, mode_active}, 16'h0000);
    checkValue("wrap_led", led, 16'h0000);
    applyStimulus(0, 0, 0, 4);
    checkValue("wrap_run", {12'h000, mode_active}, 16'h0001);

    applyStimulus(0, 0, 1, 1);
    applyStimulus(0, 0, 0, 9);
    checkValue("prev_mode", {14'h0000, cur_mode}, 16'd3);
    checkValue("prev_active", {12'h000, mode_active}, 16'h0008);

    applyStimulus(0, 1, 1, 3);
    applyStimulus(0, 0, 0, 8);
    checkValue("both_mode", {14'h0000, cur_mode}, 16'd3);
    checkValue("both_active", {12'h000, mode_active}, 16'h0008);

    applyStimulus(0, 1, 0, 1);
    applyStimulus(0, 0, 0, 2);
    applyStimulus(0, 1, 0, 1);
    applyStimulus(0, 0, 0, 9);
    checkValue("blank_drop", {14'h0000, cur_mode}, 16'd0);

    for (int p = 0; p < 2; p++) begin
      applyStimulus(0, 1, 0, 1);
      applyStimulus(0, 0, 0, 9);
    end
    checkValue("at_mode2", {14'h0000, cur_mode}, 16'd2);
    applyStimulus(1, 1, 0, 2);
    applyStimulus(0, 1, 0, 1);
    checkValue("rst_mode", {14'h0000, cur_mode}, 16'd0);
    checkValue("rst_active", {12'h000, mode_active}, 16'h0000);
    applyStimulus(0, 1, 0, 10);
    checkValue("rst_held_mode", {14'h0000, cur_mode}, 16'd0);
    checkValue("rst_held_active", {12'h000, mode_active}, 16'h0001);
    applyStimulus(0, 0, 0, 3);

    rn = 0;
    rp = 0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 4) == 0) rn = ~rn;
      if ($urandom_range(0, 5) == 0) rp = ~rp;
      applyStimulus($urandom_range(0, 149) == 0, rn, rp, 1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mode_sequencer.md
MODE_SEQUENCER -- requirements
Module: mode_sequencer

Interface
REQ-001 Parameters SHALL be, one per line:
- BLANK_CYCLES, 10_000_000, length of the inter-mode blanking interval in clk cycles; must be >= 1.
- BLANK_SEG, 16'hFFFF, seg_data value driven during blanking.
REQ-002 Ports SHALL be, one per line:
- clk  input  1  system clock; the single clock.
- reset  input  1  synchronous, active-high reset.
- btn_next  input  1  debounced level, asynchronous to clk; rising edge requests the next mode.
- btn_prev  input  1  debounced level, asynchronous to clk; rising edge requests the previous mode.
- led0..led3  input  16 each  LED pattern from mode block 0..3.
- seg0..seg3  input  16 each  4-digit seg_data from mode block 0..3.
- mode_active  output  4  one-hot enable to mode blocks; bit k drives mode k's active input.
- cur_mode  output  2  index of the selected mode.
- led  output  16  muxed LED output.
- seg_data  output  16  muxed display data.
REQ-003 Clock and reset SHALL be exactly as decided: one clock, clk; reset is synchronous and active-high, named reset.

Function
REQ-004 Each button SHALL pass through a 2-flop synchronizer, then a rising-edge detector (stage2 & ~stage2_d).
REQ-005 A button high before clk edge N SHALL register as a request at edge N+2; outputs SHALL change after edge N+2.
REQ-006 A held button SHALL produce exactly one request.
REQ-007 The FSM SHALL have two states: BLANK and RUN.
REQ-008 In BLANK, mode_active SHALL be 0, led 16'h0000, and seg_data BLANK_SEG.
REQ-009 In BLANK, blank_cnt SHALL count 0..BLANK_CYCLES-1.
- At the edge where blank_cnt==BLANK_CYCLES-1, the FSM SHALL enter RUN and set mode_active to one-hot(cur_mode).
- mode_active SHALL therefore rise exactly BLANK_CYCLES cycles after BLANK entry.
REQ-010 In RUN, led/seg_data SHALL be registered copies of led[cur_mode]/seg[cur_mode]: 1-cycle latency from the inputs.
REQ-011 On a next request in RUN:
- cur_mode SHALL increment, wrapping 3->0.
- mode_active, led and seg_data SHALL take their BLANK values on the same edge.
- The FSM SHALL enter BLANK with blank_cnt=0.
REQ-012 On a prev request in RUN, behaviour SHALL match REQ-011 except cur_mode decrements, wrapping 0->3.
REQ-013 Simultaneous next and prev requests in the same cycle SHALL be ignored: no state change.
REQ-014 Requests arriving during BLANK SHALL be discarded, not queued.
REQ-015 mode_active SHALL never have more than one bit set; no two mode blocks SHALL ever be active in the same cycle.
REQ-016 cur_mode SHALL change only on the edge that enters BLANK.

Reset
REQ-017 While reset is high at a clk edge, the block SHALL load:
- state = BLANK
- blank_cnt = 0
- cur_mode = 0
- mode_active = 4'b0000
- led = 16'h0000
- seg_data = BLANK_SEG
- all synchronizer and edge-detect flops = 0
REQ-018 Reset asserted mid-BLANK or mid-RUN SHALL take effect at the next edge, abandoning any in-progress count.
REQ-019 After reset deasserts, mode 0 SHALL become active after BLANK_CYCLES cycles.
REQ-020 A button already high during reset SHALL NOT generate a request after release.
- The edge-detect flop SHALL capture the synchronized level from the first post-reset cycle.

Structure
REQ-021 A shared package SHALL hold:
- mode index constants MODE_0..MODE_3 (MODE_3 = credits)
- the FSM state encoding (BLANK, RUN)
- BLANK_SEG default
- NUM_MODES = 4
REQ-022 One sub-module, btn_sync_edge, SHALL implement REQ-004 and the reset behaviour of REQ-020; it SHALL be instantiated twice.

Verification (BLANK_CYCLES=4)
REQ-023 Reset release, no buttons:
- mode_active=0000 and seg_data=FFFF for 4 cycles.
- Then mode_active=0001, cur_mode=0.
- seg_data=seg0 one cycle later.
REQ-024 In RUN mode 3, pulse btn_next:
- After edge N+2: cur_mode=0, mode_active=0000, led=0000.
- 4 cycles later: mode_active=0001.
REQ-025 In RUN mode 0, pulse btn_prev -> cur_mode=3; after blanking, mode_active=1000 and seg_data tracks seg3 with 1-cycle latency.
REQ-026 Hold btn_next and btn_prev high on the same cycle -> no change in cur_mode or mode_active.
REQ-027 btn_next pulse during BLANK -> ignored; cur_mode unchanged after blanking.
REQ-028 Assert reset mid-RUN at cur_mode=2, with btn_next held high through release:
- cur_mode=0, mode_active=0000.
- Mode 0 activates after 4 cycles with no spurious advance.
